ble6_bank_cfg_loader: RTL and testbench
=======================================

// Module: ble6_bank_cfg_loader
// PURPOSE
//  Sequencer that programs the ble6 memory-bank configuration: 64 LUT6 bits plus 2 output-mux bits, 66 total.
//  Accepts configuration words over a valid/ready stream into a shadow register.
//  Then writes the bank one word-line group at a time by driving bl (data) and pulsing wl (write strobe).
//  Sits between the fabric config bus and the ble6 bl/wl ports.
// PARAMETERS
//  CFG_BITS   66  configuration bits in the bank (bl/wl width)
//  DATA_W     8   stream word width; NWORDS = ceil(CFG_BITS/DATA_W) = 9
//  WL_GROUP   11  wl lines pulsed together; CFG_BITS % WL_GROUP must be 0 (NGRP = 6)
//  SETUP_CYC  1   cycles bl is stable before the wl pulse (>=1)
//  PULSE_CYC  2   wl pulse width in cycles (>=1)
//  HOLD_CYC   1   cycles bl is held after wl falls (>=1)
// PORTS
//  clk        in   1           clock; all state on rising edge
//  reset      in   1           asynchronous, active-high reset
//  cfg_start  in   1           begin a load; sampled only in IDLE
//  cfg_abort  in   1           abandon the operation; return to IDLE
//  cfg_valid  in   1           cfg_data valid
//  cfg_ready  out  1           loader accepts a word (high only in LOAD)
//  cfg_data   in   DATA_W      word k, bit j -> cfg bit k*DATA_W+j
//  bl         out  CFG_BITS    bit-line data [0:CFG_BITS-1]
//  wl         out  CFG_BITS    word-line strobes [0:CFG_BITS-1]
//  busy       out  1           high in every state except IDLE
//  done       out  1           one-cycle pulse on successful completion
//  err        out  1           sticky checksum error; cleared by the next cfg_start
// BEHAVIOUR
//  Reset: all outputs are 0 immediately (asynchronous), including bl, wl, cfg_ready, busy, done and err.
//    State goes to IDLE. The shadow register and counters are cleared.
//  Reset during a pulse drops wl in the same instant; no partial strobe is extended.
//  States: IDLE, LOAD, CHECK (macro only), SETUP, PULSE, HOLD, DONE.
//  IDLE -> LOAD on cfg_start. cfg_start in any other state is ignored.
//  LOAD:
//    - cfg_ready=1; a word is taken when cfg_valid&cfg_ready.
//    - Word counter runs 0..NWORDS-1. Bits beyond CFG_BITS in the last word are discarded (word 8 bits[7:2]).
//    - The cycle after the last handshake enters SETUP for group 0 (or CHECK if the macro is defined).
//  SETUP:
//    - bl[g*WL_GROUP +: WL_GROUP] = shadow bits of group g; every other bl bit = 0.
//    - wl = 0. Lasts SETUP_CYC cycles.
//  PULSE: bl unchanged; wl bits of group g = 1, all other wl bits = 0. Lasts PULSE_CYC cycles.
//  HOLD: wl = 0, bl unchanged, HOLD_CYC cycles.
//    - Then go to SETUP of g+1. After g = NGRP-1, go to DONE.
//  DONE: done=1 and busy=1 for exactly 1 cycle, bl=0; then IDLE.
//  Only one wl group is ever high at a time. wl is never high while bl is changing.
//  Latency with defaults: last handshake at cycle T -> SETUP g0 at T+1 -> done at T+25 (6 groups x 4 cycles).
//  cfg_abort (any non-IDLE state): next cycle is IDLE.
//    - bl, wl, cfg_ready and busy go to 0. No done pulse. err unchanged.
//    - Groups already written stay written.
//  cfg_abort and cfg_start in the same cycle in IDLE: abort wins, so the block stays IDLE.
//  cfg_valid outside LOAD is ignored, and no word is consumed.
//  Word and group counters are sized by $clog2. No wrap is possible because both counters are state-bounded.
// CONFIGURATION
//  CFG_CHECKSUM_EN defined:
//    - LOAD accepts NWORDS+1 words. The extra final word is a checksum equal to the XOR of all payload words (full DATA_W width).
//    - CHECK, 1 cycle: on match, go to SETUP g0.
//    - On mismatch: err=1, no wl pulse at all, return to IDLE with no done pulse.
//    - Added latency: 1 cycle for CHECK.
//  CFG_CHECKSUM_EN undefined:
//    - Exactly NWORDS words are accepted. No CHECK state; err is tied to 0.
// TESTING
//  T1 reset: assert reset mid-PULSE -> wl, bl, busy all 0 combinationally; IDLE after release.
//  T2 full load, all words 8'hFF (last word upper bits 1):
//    - Exactly 9 handshakes.
//    - 6 wl pulses of 2 cycles each, on wl[0:10], [11:21], ... [55:65].
//    - bl group = all 1s during each pulse; bits 66+ never appear.
//    - done at T+25.
//  T3 pattern 8'hA5 per word with random cfg_valid gaps:
//    - bl[0]=1, bl[1]=0, bl[2]=1 in g0.
//    - bl[64:65]=2'b01 in g5.
//    - Stalls add no extra words.
//  T4 cfg_abort in HOLD of g2:
//    - wl groups 0..2 pulsed, 3..5 never pulsed.
//    - No done; busy=0 next cycle; a new cfg_start runs a full load.
//  T5 (CFG_CHECKSUM_EN): 9 words of 8'h01 with checksum 8'h01 -> programs, done.
//    - Same words with checksum 8'h00 -> err=1, zero wl activity.
//    - err stays set until the next cfg_start clears it.
//  T6 cfg_start while busy, plus cfg_valid in IDLE -> ignored.
//    - Scoreboard shows one load only, with no extra handshake.

Source files
------------

// File: rtl/ble6_bank_cfg_loader.sv
// ble6 bank configuration loader: streams config words into a shadow register, then
// writes the bank one wl group at a time. Optional checksum word via CFG_CHECKSUM_EN.
module ble6_bank_cfg_loader #(
    parameter int unsigned CFG_BITS  = 66,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WL_GROUP  = 11,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [DATA_W-1:0]   cfg_data,
    output logic [CFG_BITS-1:0] bl,
    output logic [CFG_BITS-1:0] wl,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int unsigned NWORDS  = (CFG_BITS + DATA_W - 1) / DATA_W;
    localparam int unsigned NGRP    = CFG_BITS / WL_GROUP;
`ifdef CFG_CHECKSUM_EN
    localparam int unsigned LAST_WORD = NWORDS;
`else
    localparam int unsigned LAST_WORD = NWORDS - 1;
`endif
    localparam int unsigned WCNT_W  = $clog2(NWORDS + 1);
    localparam int unsigned GRP_W   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned CYC_MAX = (SETUP_CYC > PULSE_CYC) ?
                                      ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                                      ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

    localparam logic [CFG_BITS-1:0] WORD_MASK = CFG_BITS'({DATA_W{1'b1}});
    localparam logic [CFG_BITS-1:0] GRP_MASK  = CFG_BITS'({WL_GROUP{1'b1}});

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef CFG_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd6;
`endif

    logic [2:0]          r_state,  w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt,   w_wcnt_nxt;
    logic [GRP_W-1:0]    r_grp,    w_grp_nxt;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [CFG_BITS-1:0] r_shadow, w_shadow_nxt;
    logic [CFG_BITS-1:0] r_bl,     w_bl_nxt;
    logic [CFG_BITS-1:0] r_wl,     w_wl_nxt;
    logic [CFG_BITS-1:0] w_grp_mask;
    logic [31:0]         w_shamt;
    logic                w_in_wr;
    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_done;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0]   r_csum_acc, w_csum_acc_nxt;
    logic [DATA_W-1:0]   r_csum_rx,  w_csum_rx_nxt;
    logic                r_err,      w_err_nxt;
`endif

    // Next-state, counters, shadow update and next registered outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_grp_nxt    = r_grp;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_shamt      = DATA_W * 32'(r_wcnt);
`ifdef CFG_CHECKSUM_EN
        w_csum_acc_nxt = r_csum_acc;
        w_csum_rx_nxt  = r_csum_rx;
        w_err_nxt      = r_err;
`endif
        if (cfg_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        w_state_nxt = S_LOAD;
                        w_wcnt_nxt  = '0;
`ifdef CFG_CHECKSUM_EN
                        w_csum_acc_nxt = '0;
                        w_err_nxt      = 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        // shifts past CFG_BITS drop the unused top bits of the last word
                        w_shadow_nxt = (r_shadow & ~(WORD_MASK << w_shamt)) |
                                       (CFG_BITS'(cfg_data) << w_shamt);
                        w_wcnt_nxt   = r_wcnt + WCNT_W'(1);
`ifdef CFG_CHECKSUM_EN
                        if (r_wcnt == WCNT_W'(NWORDS)) w_csum_rx_nxt = cfg_data;
                        else                           w_csum_acc_nxt = r_csum_acc ^ cfg_data;
`endif
                        if (r_wcnt == WCNT_W'(LAST_WORD)) begin
                            w_wcnt_nxt = '0;
                            w_grp_nxt  = '0;
                            w_cnt_nxt  = '0;
`ifdef CFG_CHECKSUM_EN
                            w_state_nxt = S_CHECK;
`else
                            w_state_nxt = S_SETUP;
`endif
                        end
                    end
                end
`ifdef CFG_CHECKSUM_EN
                S_CHECK: begin
                    if (r_csum_acc == r_csum_rx) begin
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
`endif
                S_SETUP: begin
                    if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_PULSE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                        w_cnt_nxt = '0;
                        if (r_grp == GRP_W'(NGRP - 1)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_grp_nxt   = r_grp + GRP_W'(1);
                            w_state_nxt = S_SETUP;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_grp_mask = GRP_MASK << (WL_GROUP * 32'(w_grp_nxt));
        w_in_wr    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                     (w_state_nxt == S_HOLD);
        w_bl_nxt   = w_in_wr ? (w_shadow_nxt & w_grp_mask) : '0;
        w_wl_nxt   = (w_state_nxt == S_PULSE) ? w_grp_mask : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_grp       <= '0;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_bl        <= '0;
            r_wl        <= '0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_grp       <= w_grp_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_bl        <= w_bl_nxt;
            r_wl        <= w_wl_nxt;
            r_cfg_ready <= (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum_acc <= '0;
            r_csum_rx  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_csum_acc <= w_csum_acc_nxt;
            r_csum_rx  <= w_csum_rx_nxt;
            r_err      <= w_err_nxt;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bl        = r_bl;
    assign wl        = r_wl;

endmodule

// File: tb/tb_ble6_bank_cfg_loader.sv
// Directed bench for ble6_bank_cfg_loader (default parameters); CFG_CHECKSUM_EN
// adds the checksum word to every load and enables the checksum scenarios.
module tb_ble6_bank_cfg_loader;
    localparam int CFG_BITS = 66;
    localparam int DATA_W   = 8;
    localparam int WLG      = 11;
    localparam int NGRP     = 6;
    localparam int NWORDS   = 9;
`ifdef CFG_CHECKSUM_EN
    localparam int LAT     = 25;
    localparam int NW_SEND = NWORDS + 1;
`else
    localparam int LAT     = 24;
    localparam int NW_SEND = NWORDS;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_start;
    logic                cfg_abort;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [DATA_W-1:0]   cfg_data;
    logic [CFG_BITS-1:0] bl;
    logic [CFG_BITS-1:0] wl;
    logic                busy;
    logic                done;
    logic                err;

    ble6_bank_cfg_loader dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .bl        (bl),
        .wl        (wl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Bus monitor state, cleared by mon_clr
    logic                mon_clr = 1'b0;
    int                  hs_cnt = 0;
    int                  done_cnt = 0;
    int                  bad_cnt = 0;
    int                  pulse_cyc [NGRP];
    logic [WLG-1:0]      bl_grp [NGRP];
    logic [CFG_BITS-1:0] prev_wl = '0;
    logic [CFG_BITS-1:0] prev_bl = '0;
    bit                  mon_found;

    function automatic logic [CFG_BITS-1:0] gmask(input int g);
        logic [CFG_BITS-1:0] m;
        m = '0;
        m[WLG-1:0] = '1;
        return m << (g * WLG);
    endfunction

    // Expected bl slice of group g when every stream word equals w
    function automatic logic [WLG-1:0] exp_grp(input logic [DATA_W-1:0] w, input int g);
        logic [WLG-1:0] r;
        int b;
        for (int i = 0; i < WLG; i++) begin
            b = (g * WLG + i) % DATA_W;
            r[i] = w[b];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_clr) begin
            hs_cnt   = 0;
            done_cnt = 0;
            bad_cnt  = 0;
            for (int g = 0; g < NGRP; g++) begin
                pulse_cyc[g] = 0;
                bl_grp[g]    = '0;
            end
        end else if (!reset) begin
            if (cfg_valid && cfg_ready) hs_cnt++;
            if (done) done_cnt++;
            if ((wl != '0 || prev_wl != '0) && bl != prev_bl) bad_cnt++;
            if (wl != '0) begin
                mon_found = 1'b0;
                for (int g = 0; g < NGRP; g++) begin
                    if (wl == gmask(g)) begin
                        mon_found = 1'b1;
                        pulse_cyc[g]++;
                        bl_grp[g] = bl[g*WLG +: WLG];
                        if ((bl & ~gmask(g)) != '0) bad_cnt++;
                    end
                end
                if (!mon_found) bad_cnt++;
            end
        end
        prev_wl = wl;
        prev_bl = bl;
    end

    task automatic check(input string tag, input logic [CFG_BITS-1:0] obs,
                         input logic [CFG_BITS-1:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input int gap);
        cfg_valid = 1'b0;
        repeat (gap) tick();
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int k = 0; k < 20 && !cfg_ready; k++) tick();
        tick();
        cfg_valid = 1'b0;
    endtask

    // Full load of identical words; the checksum of an odd count of equal words is the word
    task automatic send_load(input logic [DATA_W-1:0] w, input bit gaps);
        for (int k = 0; k < NWORDS; k++) send_word(w, gaps ? (k % 3) : 0);
`ifdef CFG_CHECKSUM_EN
        send_word(w, 0);
`endif
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_pulses(input string tag, input int lo, input int hi, input int expv);
        for (int g = lo; g <= hi; g++)
            check($sformatf("%s pulse g%0d", tag, g), CFG_BITS'(pulse_cyc[g]), CFG_BITS'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        for (int g = 0; g < NGRP; g++) begin
            pulse_cyc[g] = 0;
            bl_grp[g]    = '0;
        end
        #12;
        check("reset bl", bl, '0);
        check("reset wl", wl, '0);
        check("reset busy", CFG_BITS'(busy), '0);
        check("reset ready", CFG_BITS'(cfg_ready), '0);
        check("reset done", CFG_BITS'(done), '0);
        check("reset err", CFG_BITS'(err), '0);
        reset = 1'b0;
        tick();
        clear_mon();

        // T2: all-ones load
        start_load();
        check("T2 ready in load", CFG_BITS'(cfg_ready), 1);
        check("T2 busy in load", CFG_BITS'(busy), 1);
        send_load(8'hFF, 1'b0);
        check("T2 ready after load", CFG_BITS'(cfg_ready), 0);
        wait_done(n);
        check("T2 done latency", CFG_BITS'(n), CFG_BITS'(LAT));
        tick();
        check("T2 done one cycle", CFG_BITS'(done), 0);
        check("T2 busy after done", CFG_BITS'(busy), 0);
        check("T2 handshakes", CFG_BITS'(hs_cnt), CFG_BITS'(NW_SEND));
        check_pulses("T2", 0, NGRP - 1, 2);
        for (int g = 0; g < NGRP; g++)
            check($sformatf("T2 bl g%0d", g), CFG_BITS'(bl_grp[g]), CFG_BITS'(11'h7FF));
        check("T2 protocol", CFG_BITS'(bad_cnt), 0);
        check("T2 done count", CFG_BITS'(done_cnt), 1);
        check("T2 err", CFG_BITS'(err), 0);

        // T3: 8'hA5 words with valid gaps
        clear_mon();
        start_load();
        send_load(8'hA5, 1'b1);
        wait_done(n);
        check("T3 done latency", CFG_BITS'(n), CFG_BITS'(LAT));
        tick();
        check("T3 handshakes", CFG_BITS'(hs_cnt), CFG_BITS'(NW_SEND));
        check("T3 g0 full", CFG_BITS'(bl_grp[0]), CFG_BITS'(11'h5A5));
        check("T3 g0 bits 2:0", CFG_BITS'(bl_grp[0][2:0]), CFG_BITS'(3'b101));
        check("T3 g5 bits 65:64", CFG_BITS'(bl_grp[5][10:9]), CFG_BITS'(2'b01));
        for (int g = 1; g < NGRP; g++)
            check($sformatf("T3 bl g%0d", g), CFG_BITS'(bl_grp[g]), CFG_BITS'(exp_grp(8'hA5, g)));
        check("T3 protocol", CFG_BITS'(bad_cnt), 0);

        // T4: abort in HOLD of group 2, then a full reload
        clear_mon();
        start_load();
        send_load(8'h3C, 1'b0);
        n = 0;
        while (wl !== gmask(2) && n < 100) begin tick(); n++; end
        while (wl !== '0 && n < 100) begin tick(); n++; end
        check("T4 bl in hold g2", bl, CFG_BITS'(exp_grp(8'h3C, 2)) << (2 * WLG));
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("T4 busy after abort", CFG_BITS'(busy), 0);
        check("T4 bl after abort", bl, '0);
        check("T4 wl after abort", wl, '0);
        repeat (30) tick();
        check_pulses("T4", 0, 2, 2);
        check_pulses("T4", 3, NGRP - 1, 0);
        check("T4 no done", CFG_BITS'(done_cnt), 0);
        clear_mon();
        start_load();
        send_load(8'h3C, 1'b0);
        wait_done(n);
        check("T4 reload latency", CFG_BITS'(n), CFG_BITS'(LAT));
        tick();
        check_pulses("T4 reload", 0, NGRP - 1, 2);
        check("T4 reload bl g4", CFG_BITS'(bl_grp[4]), CFG_BITS'(exp_grp(8'h3C, 4)));

        // T6: valid in IDLE, abort+start together, start while busy
        clear_mon();
        cfg_data = 8'h99; cfg_valid = 1'b1;
        repeat (3) tick();
        check("T6 ready in idle", CFG_BITS'(cfg_ready), 0);
        cfg_valid = 1'b0;
        check("T6 idle handshakes", CFG_BITS'(hs_cnt), 0);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        check("T6 abort beats start", CFG_BITS'(busy), 0);
        start_load();
        send_load(8'h0F, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h77;
        repeat (5) tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        wait_done(n);
        check("T6 latency", CFG_BITS'(n + 5), CFG_BITS'(LAT));
        repeat (4) tick();
        check("T6 idle after done", CFG_BITS'(busy), 0);
        check("T6 handshakes", CFG_BITS'(hs_cnt), CFG_BITS'(NW_SEND));
        check("T6 done count", CFG_BITS'(done_cnt), 1);
        check("T6 bl g1", CFG_BITS'(bl_grp[1]), CFG_BITS'(exp_grp(8'h0F, 1)));

        // T1: reset in the middle of a pulse
        clear_mon();
        start_load();
        send_load(8'hFF, 1'b0);
        n = 0;
        while (wl === '0 && n < 50) begin tick(); n++; end
        check("T1 pulsing g0", wl, gmask(0));
        reset = 1'b1;
        #1;
        check("T1 wl in reset", wl, '0);
        check("T1 bl in reset", bl, '0);
        check("T1 busy in reset", CFG_BITS'(busy), 0);
        #2;
        reset = 1'b0;
        tick();
        check("T1 idle after reset", CFG_BITS'(busy), 0);
        check("T1 wl after reset", wl, '0);
        start_load();
        check("T1 restart ready", CFG_BITS'(cfg_ready), 1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("T1 abort in load", CFG_BITS'(cfg_ready), 0);

`ifdef CFG_CHECKSUM_EN
        // T5: checksum match then mismatch
        clear_mon();
        start_load();
        send_load(8'h01, 1'b0);
        wait_done(n);
        check("T5 good latency", CFG_BITS'(n), CFG_BITS'(LAT));
        tick();
        check("T5 good err", CFG_BITS'(err), 0);
        check_pulses("T5 good", 0, NGRP - 1, 2);
        clear_mon();
        start_load();
        for (int k = 0; k < NWORDS; k++) send_word(8'h01, 0);
        send_word(8'h00, 0);
        repeat (5) tick();
        check("T5 bad err", CFG_BITS'(err), 1);
        check("T5 bad busy", CFG_BITS'(busy), 0);
        check("T5 bad done", CFG_BITS'(done_cnt), 0);
        check_pulses("T5 bad", 0, NGRP - 1, 0);
        repeat (5) tick();
        check("T5 err sticky", CFG_BITS'(err), 1);
        start_load();
        check("T5 err cleared", CFG_BITS'(err), 0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
